writeback_unit: RTL and testbench

Writeback arbiter and register scoreboard that drives the integer regfile write port (`w_enable`, `rd_num`, `rd_data`). It merges single-cycle ALU results with variable-latency load results from the LSU and buffers the load results. It tracks destination registers of outstanding loads and tells decode when to stall on a RAW hazard. It sits between execute/LSU and the regfile; an optional bypass forwards the in-flight write to the regfile read ports.

---
 rtl/writeback_unit_pkg.sv | 16 +
 rtl/writeback_unit_fifo.sv | 71 +++++++
 rtl/writeback_unit.sv | 146 ++++++++++++++
 tb/tb_writeback_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_unit_pkg.sv
// Shared core types for the writeback path: register index, data word and
// the {rd, data} entry carried through the load-result buffer.
package writeback_unit_pkg;

    localparam int XLEN = 32;
    localparam int RAW  = 5;

    typedef logic [XLEN-1:0] data_t;
    typedef logic [RAW-1:0]  reg_addr_t;

    typedef struct packed {
        reg_addr_t rd;
        data_t     data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_unit_fifo.sv
// wb_fifo: synchronous FIFO of wb_entry_t with full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
    import writeback_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t wdata,
    output wb_entry_t rdata,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    wb_entry_t       mem_q [DEPTH];
    wb_entry_t       mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign rdata   = mem_q[rd_ptr_q];
    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU results and buffered load results onto the
// regfile write port, keeps the outstanding-load scoreboard and raises
// decode/execute stalls.
// Optional feature: define WB_BYPASS_EN to forward the output-stage write
// to rs1_data/rs2_data instead of stalling decode on it.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int LSU_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  reg_addr_t       alu_rd,
    input  data_t           alu_data,
    input  logic            lsu_issue,
    input  reg_addr_t       lsu_issue_rd,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  reg_addr_t       lsu_rd,
    input  data_t           lsu_data,
    output logic            w_enable,
    output reg_addr_t       rd_num,
    output data_t           rd_data,
    input  reg_addr_t       rs1_num,
    input  reg_addr_t       rs2_num,
    input  data_t           rf_rs1_data,
    input  data_t           rf_rs2_data,
    output data_t           rs1_data,
    output data_t           rs2_data,
    output logic            hazard_stall,
    output logic            stall_req,
    output logic [XLEN-1:0] busy_vec
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic            w_enable_q, w_enable_d;
    reg_addr_t       rd_num_q, rd_num_d;
    data_t           rd_data_q, rd_data_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            stall_req_q, stall_req_d;
    logic [XLEN-1:0] busy_q, busy_d;

    logic      alu_win;
    logic      fifo_push, fifo_pop, fifo_full, fifo_empty;
    wb_entry_t fifo_wdata, fifo_rdata;
    logic      haz1, haz2;

    assign alu_win    = alu_valid && (alu_rd != '0);
    assign lsu_ready  = !fifo_full;
    // rd=0 loads complete the handshake but never occupy a slot.
    assign fifo_push  = lsu_valid && lsu_ready && (lsu_rd != '0);
    assign fifo_pop   = !fifo_empty && !alu_win;
    assign fifo_wdata = '{rd: lsu_rd, data: lsu_data};

    wb_fifo #(.DEPTH(LSU_FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Arbitration, starvation counter and scoreboard next-state.
    always_comb begin
        w_enable_d = 1'b0;
        rd_num_d   = '0;
        rd_data_d  = '0;
        if (alu_win) begin
            w_enable_d = 1'b1;
            rd_num_d   = alu_rd;
            rd_data_d  = alu_data;
        end else if (fifo_pop) begin
            w_enable_d = 1'b1;
            rd_num_d   = fifo_rdata.rd;
            rd_data_d  = fifo_rdata.data;
        end

        // Non-empty without a pop can only mean the ALU took the slot.
        starve_d = starve_q;
        if (fifo_empty || fifo_pop) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end
        stall_req_d = (starve_d == STARVE_MAX);

        // Clear before set so an issue to the same rd wins.
        busy_d = busy_q;
        if (fifo_pop) begin
            busy_d[fifo_rdata.rd] = 1'b0;
        end
        if (lsu_issue && (lsu_issue_rd != '0)) begin
            busy_d[lsu_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Output stage and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_enable_q  <= 1'b0;
            rd_num_q    <= '0;
            rd_data_q   <= '0;
            starve_q    <= '0;
            stall_req_q <= 1'b0;
            busy_q      <= '0;
        end else begin
            w_enable_q  <= w_enable_d;
            rd_num_q    <= rd_num_d;
            rd_data_q   <= rd_data_d;
            starve_q    <= starve_d;
            stall_req_q <= stall_req_d;
            busy_q      <= busy_d;
        end
    end

    assign w_enable  = w_enable_q;
    assign rd_num    = rd_num_q;
    assign rd_data   = rd_data_q;
    assign stall_req = stall_req_q;
    assign busy_vec  = busy_q;

    // Read-port forwarding and RAW hazard detection.
    always_comb begin
`ifdef WB_BYPASS_EN
        rs1_data = (w_enable_q && (rd_num_q == rs1_num) && (rs1_num != '0)) ? rd_data_q : rf_rs1_data;
        rs2_data = (w_enable_q && (rd_num_q == rs2_num) && (rs2_num != '0)) ? rd_data_q : rf_rs2_data;
        haz1     = (rs1_num != '0) && busy_q[rs1_num];
        haz2     = (rs2_num != '0) && busy_q[rs2_num];
`else
        rs1_data = rf_rs1_data;
        rs2_data = rf_rs2_data;
        haz1     = (rs1_num != '0) && (busy_q[rs1_num] || (w_enable_q && (rd_num_q == rs1_num)));
        haz2     = (rs2_num != '0) && (busy_q[rs2_num] || (w_enable_q && (rd_num_q == rs2_num)));
`endif
        hazard_stall = haz1 || haz2;
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed stimulus with an ALU queue and a
// load queue as scoreboard; ALU writes take priority, loads leave in order.
module tb_writeback_unit;
    import writeback_unit_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alu_valid;
    reg_addr_t       alu_rd;
    data_t           alu_data;
    logic            lsu_issue;
    reg_addr_t       lsu_issue_rd;
    logic            lsu_valid;
    logic            lsu_ready;
    reg_addr_t       lsu_rd;
    data_t           lsu_data;
    logic            w_enable;
    reg_addr_t       rd_num;
    data_t           rd_data;
    reg_addr_t       rs1_num;
    reg_addr_t       rs2_num;
    data_t           rf_rs1_data;
    data_t           rf_rs2_data;
    data_t           rs1_data;
    data_t           rs2_data;
    logic            hazard_stall;
    logic            stall_req;
    logic [XLEN-1:0] busy_vec;

    writeback_unit #(.LSU_FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .lsu_issue    (lsu_issue),
        .lsu_issue_rd (lsu_issue_rd),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .w_enable     (w_enable),
        .rd_num       (rd_num),
        .rd_data      (rd_data),
        .rs1_num      (rs1_num),
        .rs2_num      (rs2_num),
        .rf_rs1_data  (rf_rs1_data),
        .rf_rs2_data  (rf_rs2_data),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .hazard_stall (hazard_stall),
        .stall_req    (stall_req),
        .busy_vec     (busy_vec)
    );

    always #5 clk = ~clk;

    int        n_vec  = 0;
    int        n_miss = 0;
    wb_entry_t alu_q [$];
    wb_entry_t ld_q  [$];
    logic      exp_alu = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid    = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_issue    = 1'b0; lsu_issue_rd = '0;
        lsu_valid    = 1'b0; lsu_rd = '0; lsu_data = '0;
        rs1_num      = '0; rs2_num = '0;
        rf_rs1_data  = '0; rf_rs2_data = '0;
    endtask

    // Scoreboard: check the write produced by last cycle's decision, then
    // record what this cycle's inputs will produce.
    always @(negedge clk) begin
        if (!rst_n) begin
            alu_q.delete();
            ld_q.delete();
            exp_alu <= 1'b0;
        end else begin
            if (exp_alu) begin
                check("alu_w_enable", 64'(w_enable), 64'd1);
                if (alu_q.size() > 0) begin
                    check("alu_rd", 64'(rd_num), 64'(alu_q[0].rd));
                    check("alu_data", 64'(rd_data), 64'(alu_q[0].data));
                    void'(alu_q.pop_front());
                end
            end else if (w_enable) begin
                if (ld_q.size() == 0) begin
                    check("stray_write", 64'(rd_num), 64'hFFFF);
                end else begin
                    check("ld_rd", 64'(rd_num), 64'(ld_q[0].rd));
                    check("ld_data", 64'(rd_data), 64'(ld_q[0].data));
                    void'(ld_q.pop_front());
                end
            end
            exp_alu <= alu_valid && (alu_rd != '0);
            if (alu_valid && (alu_rd != '0)) alu_q.push_back('{rd: alu_rd, data: alu_data});
            if (lsu_valid && lsu_ready && (lsu_rd != '0)) ld_q.push_back('{rd: lsu_rd, data: lsu_data});
        end
    end

    initial begin
        int wins;
        int guard;
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_w_enable", 64'(w_enable), 64'd0);
        check("rst_rd_num", 64'(rd_num), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check("rst_lsu_ready", 64'(lsu_ready), 64'd1);
        check("rst_busy", 64'(busy_vec), 64'd0);
        check("rst_stall_req", 64'(stall_req), 64'd0);
        rst_n = 1'b1;
        tick();

        // ALU pass-through, then ALU x0 and a load to x0: neither writes.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        tick();
        check("pt_w_enable", 64'(w_enable), 64'd1);
        check("pt_rd_num", 64'(rd_num), 64'd5);
        check("pt_rd_data", 64'(rd_data), 64'h1234);
        alu_rd = 5'd0; alu_data = 32'h5555;
        tick();
        alu_valid = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hBAD;
        check("x0_w_enable", 64'(w_enable), 64'd0);
        tick();
        lsu_valid = 1'b0;
        tick();
        check("ld_x0_w_enable", 64'(w_enable), 64'd0);
        tick();
        check("ld_x0_w_enable2", 64'(w_enable), 64'd0);

        // Load x7 while the ALU streams into x3.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3000;
        lsu_issue = 1'b1; lsu_issue_rd = 5'd7;
        tick();
        lsu_issue = 1'b0;
        rs1_num = 5'd7;
        #1;
        check("busy7_set", 64'(busy_vec[7]), 64'd1);
        check("haz_rs1_7", 64'(hazard_stall), 64'd1);
        alu_data = 32'h3001;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hDEAD;
        tick();
        lsu_valid = 1'b0;
        wins = 0;
        while (!stall_req && wins < 20) begin
            alu_data = alu_data + 1;
            tick();
            wins++;
        end
        check("starve_wins", 64'(wins), 64'd4);
        check("stall_req_hi", 64'(stall_req), 64'd1);
        alu_valid = 1'b0;
        tick();
        check("bubble_w_enable", 64'(w_enable), 64'd1);
        check("bubble_rd_num", 64'(rd_num), 64'd7);
        check("busy7_clr", 64'(busy_vec[7]), 64'd0);
        check("stall_req_lo", 64'(stall_req), 64'd0);
        idle();
        repeat (2) tick();

        // FIFO full under a continuous ALU stream.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h4000;
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'h10A;
        tick();
        lsu_rd = 5'd11; lsu_data = 32'h10B;
        tick();
        check("full_ready0", 64'(lsu_ready), 64'd0);
        lsu_rd = 5'd12; lsu_data = 32'h10C;
        tick();
        check("full_ready0_held", 64'(lsu_ready), 64'd0);
        alu_valid = 1'b0;
        guard = 0;
        while (!lsu_ready && guard < 10) begin
            tick();
            guard++;
        end
        check("full_ready_back", 64'(lsu_ready), 64'd1);
        tick();
        lsu_valid = 1'b0;
        repeat (6) tick();
        check("full_drained_ready", 64'(lsu_ready), 64'd1);

        // Issue of x9 on the same edge a buffered x9 result pops.
        idle();
        lsu_issue = 1'b1; lsu_issue_rd = 5'd9;
        tick();
        lsu_issue = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
        tick();
        lsu_valid = 1'b0;
        lsu_issue = 1'b1; lsu_issue_rd = 5'd9;
        tick();
        lsu_issue = 1'b0;
        check("sc_w_enable", 64'(w_enable), 64'd1);
        check("sc_rd_num", 64'(rd_num), 64'd9);
        check("sc_busy9_kept", 64'(busy_vec[9]), 64'd1);
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h9A;
        tick();
        lsu_valid = 1'b0;
        repeat (2) tick();
        check("sc_busy9_clr", 64'(busy_vec[9]), 64'd0);
        tick();

        // Output-stage forwarding versus stall.
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hAA;
        tick();
        alu_valid = 1'b0;
        rs1_num = 5'd4; rs2_num = 5'd4;
        rf_rs1_data = 32'h55; rf_rs2_data = 32'h66;
        #1;
`ifdef WB_BYPASS_EN
        check("byp_rs1_data", 64'(rs1_data), 64'hAA);
        check("byp_rs2_data", 64'(rs2_data), 64'hAA);
        check("byp_no_stall", 64'(hazard_stall), 64'd0);
`else
        check("nobyp_rs1_data", 64'(rs1_data), 64'h55);
        check("nobyp_rs2_data", 64'(rs2_data), 64'h66);
        check("nobyp_stall", 64'(hazard_stall), 64'd1);
`endif
        rs1_num = 5'd0; rs2_num = 5'd0;
        #1;
        check("rs0_no_stall", 64'(hazard_stall), 64'd0);
        check("rs0_rs1_data", 64'(rs1_data), 64'h55);
        tick();

        // Asynchronous reset with two buffered loads and busy bits set.
        idle();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h6000;
        lsu_issue = 1'b1; lsu_issue_rd = 5'd20;
        lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'hA20;
        tick();
        lsu_issue_rd = 5'd21;
        lsu_rd = 5'd21; lsu_data = 32'hA21;
        tick();
        lsu_issue = 1'b0; lsu_valid = 1'b0;
        check("pre_rst_ready", 64'(lsu_ready), 64'd0);
        check("pre_rst_busy", 64'(busy_vec), 64'h0030_0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_w_enable", 64'(w_enable), 64'd0);
        check("mid_rst_rd_num", 64'(rd_num), 64'd0);
        check("mid_rst_rd_data", 64'(rd_data), 64'd0);
        check("mid_rst_busy", 64'(busy_vec), 64'd0);
        check("mid_rst_stall", 64'(stall_req), 64'd0);
        alu_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("post_rst_ready", 64'(lsu_ready), 64'd1);
        repeat (6) tick();
        check("post_rst_w_enable", 64'(w_enable), 64'd0);
        check("post_rst_busy", 64'(busy_vec), 64'd0);

        check("alu_q_left", 64'(alu_q.size()), 64'd0);
        check("ld_q_left", 64'(ld_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
